uart_tx_queue: RTL and testbench
================================

# uart_tx_queue

Byte queue that sits directly upstream of the UART top level and feeds its `tx_start`/`tx_data` transmit inputs. A producer pushes bytes over a valid/ready interface. The block buffers them in a circular FIFO and launches them one at a time, using the transmitter's `tx_busy` for flow control. Without it, the transmitter would accept only one byte per frame time.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `BUSY_WAIT`, 16: max cycles to wait for `tx_busy` to rise after a `tx_start` pulse; ≥ 1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_data`  in  8  byte to enqueue.
- `wr_valid`  in  1  producer has a byte.
- `wr_ready`  out  1  queue can accept a byte; equals `!full`.
- `tx_busy`  in  1  from the transmitter.
- `tx_start`  out  1  single-cycle launch pulse to the transmitter; registered.
- `tx_data`  out  8  byte being launched; registered.
- `empty`  out  1  FIFO holds 0 entries.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `level`  out  log2(DEPTH)+1  current entry count; present only under `UART_TXQ_LEVEL_EN`.

## Operation
- **Write:** a write is accepted in any cycle with `wr_valid && wr_ready`. The byte is stored at `wr_ptr`, then `wr_ptr` increments.
- **Pointers:** `wr_ptr` and `rd_ptr` are log2(DEPTH)+1 bits wide, with an extra wrap bit.
  - `empty`: pointers are equal.
  - `full`: the MSBs differ and the remaining bits are equal.
  - Wrap-around is natural modulo 2·DEPTH.
- **Count:** the count updates by +1 on a write, −1 on a pop, and is unchanged when both happen in the same cycle.
- **State machine states:**
  - IDLE: if `!empty && !tx_busy`, pop the head entry, load `tx_data` from it, drive `tx_start` ← 1, and go to ARM.
  - ARM: drive `tx_start` ← 0.
    - If `tx_busy` = 1, go to SEND.
    - Otherwise, if the wait counter reaches `BUSY_WAIT`, go to IDLE. The byte counts as sent and is not re-queued.
  - SEND: when `tx_busy` = 0, go to IDLE.
- `tx_data` holds its value from the pop until the next pop.
- **Full plus pop in the same cycle:** `wr_ready` comes from the registered full state, so the write is refused. The producer retries next cycle.
- **Write while empty:** the byte cannot be popped in the same cycle; there is no fall-through.
- **Busy at startup:** if `tx_busy` is already high in IDLE, no pop occurs.
- **Reset (any time, including mid-frame):**
  - Pointers, count and wait counter clear to 0; state returns to IDLE; queued bytes are discarded.
  - Outputs: `tx_start` = 0, `tx_data` = 8'h00, `empty` = 1, `full` = 0, `wr_ready` = 1, `level` = 0.

## Timing
- **Latency:** a write accepted in cycle 0 into an empty queue, with `tx_busy` low, makes `empty` = 0 in cycle 1. `tx_start` is high in cycle 2 only.
- **Back-to-back:** the next byte can launch no earlier than the cycle after `tx_busy` is seen low in SEND.
- **Status flags:** `wr_ready`, `empty`, `full` and `level` all change in the cycle after the access that caused the change.
- **Timeout:** exactly `BUSY_WAIT` cycles are spent in ARM when `tx_busy` never rises.

## Configuration
- `UART_TXQ_LEVEL_EN` defined: the `level` port exists and shows the registered count.
- `UART_TXQ_LEVEL_EN` undefined: the `level` port is absent. The internal count is still used for `full`/`empty`, and all other behaviour is identical.

## Structure
- **Shared package `uart_pkg`:**
  - state enum `txq_state_t` (IDLE, ARM, SEND);
  - `UART_DATA_W` = 8;
  - a log2 helper function for pointer width.
- **Sub-module `uart_txq_ram`:** DEPTH×8 register array with one write port and one read port, read combinationally at `rd_ptr`.
- The top level of this block holds the pointers, flags and state machine.

## Test plan
- **Reset values:** assert `rst` low mid-run → all outputs take their reset values immediately, before any clock edge. The queue is empty after release.
- **Single byte:** write 8'hA5 in cycle 0 with `tx_busy` = 0 → `tx_start` = 1 in cycle 2 only, and `tx_data` = 8'hA5. Raise `tx_busy` for 10 cycles, then drop it → state returns to IDLE and no extra `tx_start` occurs.
- **Fill with DEPTH = 4:** hold `tx_busy` = 1 and offer 8'h01–8'h05 → four bytes are accepted, `full` = 1, `wr_ready` = 0, and 8'h05 is held. Release `tx_busy` → bytes 8'h01, 8'h02, 8'h03, 8'h04 launch in order, then 8'h05 after it is accepted.
- **Wrap-around:** stream 2·DEPTH+3 incrementing bytes with an emulated transmitter → output order equals input order, with no loss or duplication.
- **Timeout:** keep `tx_busy` stuck low → each `tx_start` is followed by `BUSY_WAIT` cycles in ARM. The next byte launches `BUSY_WAIT`+1 cycles after the previous pulse.
- **Reset mid-frame:** pulse `rst` with 3 bytes queued and the machine in SEND → `empty` = 1, `tx_start` = 0, and the queued bytes are never launched.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-queue FSM states, byte width and a log2 helper
// used to size FIFO pointers.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SEND = 2'd2
  } txq_state_t;

  // Ceiling log2 for elaboration-time sizing; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_txq_ram.sv
// DEPTH x byte storage for the UART transmit queue: one synchronous write port
// and one combinational read port.
module uart_txq_ram
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic [AW-1:0]          rd_addr,
  output logic [UART_DATA_W-1:0] rd_data
);

  logic [UART_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_queue.sv
// Circular byte FIFO feeding the UART transmitter's tx_start/tx_data, paced by tx_busy.
// Optional `level` output is built when UART_TXQ_LEVEL_EN is defined.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int BUSY_WAIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [UART_DATA_W-1:0] tx_data,
  output logic                   empty,
  output logic                   full
`ifdef UART_TXQ_LEVEL_EN
  ,
  output logic [clog2(DEPTH):0]  level
`endif
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = clog2(BUSY_WAIT + 1);

  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          count;
  logic [WW-1:0]          wait_cnt;
  txq_state_t             state;
  logic                   wr_en;
  logic                   pop;
  logic [UART_DATA_W-1:0] rd_data;

  // Flags derive only from registered state, so a pop never frees a slot in the same cycle.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (count == PW'(DEPTH));
  assign wr_ready = !full;
  assign wr_en    = wr_valid && wr_ready;
  assign pop      = (state == IDLE) && !empty && !tx_busy;

`ifdef UART_TXQ_LEVEL_EN
  assign level = count;
`endif

  uart_txq_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

  // wait_cnt is loaded with 1 on launch so ARM lasts exactly BUSY_WAIT cycles on timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_start <= 1'b0;
          if (pop) begin
            tx_start <= 1'b1;
            tx_data  <= rd_data;
            wait_cnt <= WW'(1);
            state    <= ARM;
          end
        end
        ARM: begin
          tx_start <= 1'b0;
          if (tx_busy) begin
            state <= SEND;
          end else if (wait_cnt == WW'(BUSY_WAIT)) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        SEND: begin
          tx_start <= 1'b0;
          if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: begin
          tx_start <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue (DEPTH=4, BUSY_WAIT=5) with a launch log and
// an optional emulated transmitter driving tx_busy.
module tb_uart_tx_queue;

  localparam int DEPTH     = 4;
  localparam int BUSY_WAIT = 5;

  logic       clk;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       empty;
  logic       full;
`ifdef UART_TXQ_LEVEL_EN
  logic [2:0] level;
`endif

  logic       emu_en;
  logic       man_busy;
  int         emu_cnt;
  int         cyc;
  int         checks;
  int         failures;
  logic [7:0] lq_data [$];
  int         lq_cyc  [$];

  uart_tx_queue #(
    .DEPTH     (DEPTH),
    .BUSY_WAIT (BUSY_WAIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .empty    (empty),
    .full     (full)
`ifdef UART_TXQ_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Emulated transmitter: busy for 6 cycles starting the cycle after each tx_start.
  always @(posedge clk) begin
    if (!emu_en) emu_cnt <= 0;
    else if (tx_start) emu_cnt <= 6;
    else if (emu_cnt > 0) emu_cnt <= emu_cnt - 1;
  end
  assign tx_busy = emu_en ? (emu_cnt > 0) : man_busy;

  always @(posedge clk) begin
    if (tx_start) begin
      lq_data.push_back(tx_data);
      lq_cyc.push_back(cyc);
    end
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    wr_data  = b;
    wr_valid = 1'b1;
    while (!wr_ready && n < 100) begin
      step();
      n++;
    end
    check("push_wait", 32'(n < 100), 1);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_launches(input int target, input int bound);
    int n;
    n = 0;
    while (lq_data.size() < target && n < bound) begin
      step();
      n++;
    end
    check("launch_count", lq_data.size(), target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    cyc      = 0;
    checks   = 0;
    failures = 0;
    emu_en   = 1'b0;
    man_busy = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    rst      = 1'b1;

    // Reset values, observed before any clock edge.
    #2 rst = 1'b0;
    #1;
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_wr_ready", wr_ready, 1);
`ifdef UART_TXQ_LEVEL_EN
    check("rst_level", level, 0);
`endif
    repeat (2) step();
    rst = 1'b1;
    step();

    // Single byte: write in cycle 0, tx_start in cycle 2 only.
    base     = lq_data.size();
    wr_data  = 8'hA5;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    check("a_empty_c1", empty, 0);
    check("a_start_c1", tx_start, 0);
    step();
    check("a_start_c2", tx_start, 1);
    check("a_data_c2", tx_data, 8'hA5);
    man_busy = 1'b1;
    step();
    check("a_start_c3", tx_start, 0);
    check("a_empty_c3", empty, 1);
    repeat (9) step();
    man_busy = 1'b0;
    repeat (10) step();
    check("a_one_launch", lq_data.size(), base + 1);
    check("a_data_hold", tx_data, 8'hA5);

    // Fill with busy held high; fifth byte must be held off.
    base     = lq_data.size();
    man_busy = 1'b1;
    for (int i = 1; i <= 4; i++) push(8'(i));
    wr_data  = 8'h05;
    wr_valid = 1'b1;
    step();
    check("b_full", full, 1);
    check("b_wr_ready", wr_ready, 0);
    check("b_empty", empty, 0);
`ifdef UART_TXQ_LEVEL_EN
    check("b_level", level, 4);
`endif
    step();
    check("b_no_launch", lq_data.size(), base);
    emu_en = 1'b1;
    push(8'h05);
    wait_launches(base + 5, 200);
    for (int i = 0; i < 5; i++) begin
      if (base + i < lq_data.size()) check("b_order", lq_data[base+i], 32'(i + 1));
    end

    // Wrap-around stream of 2*DEPTH+3 bytes through the emulated transmitter.
    base = lq_data.size();
    for (int i = 0; i < 2 * DEPTH + 3; i++) push(8'h10 + 8'(i));
    wait_launches(base + 2 * DEPTH + 3, 400);
    for (int i = 0; i < 2 * DEPTH + 3; i++) begin
      if (base + i < lq_data.size()) check("c_order", lq_data[base+i], 32'h10 + 32'(i));
    end
    repeat (10) step();
    check("c_no_extra", lq_data.size(), base + 2 * DEPTH + 3);

    // Timeout: busy stuck low, launches spaced BUSY_WAIT+1 cycles.
    emu_en   = 1'b0;
    man_busy = 1'b0;
    base     = lq_data.size();
    push(8'h40);
    push(8'h41);
    wait_launches(base + 2, 60);
    if (lq_data.size() >= base + 2) begin
      check("d_spacing", lq_cyc[base+1] - lq_cyc[base], BUSY_WAIT + 1);
      check("d_data0", lq_data[base], 8'h40);
      check("d_data1", lq_data[base+1], 8'h41);
    end
    repeat (BUSY_WAIT + 3) step();

    // Reset mid-frame with three bytes queued behind a frame in SEND.
    base = lq_data.size();
    push(8'h77);
    step();
    check("e_start", tx_start, 1);
    man_busy = 1'b1;
    step();
    push(8'h81);
    push(8'h82);
    push(8'h83);
    check("e_queued_empty", empty, 0);
    #3 rst = 1'b0;
    #1;
    check("e_rst_empty", empty, 1);
    check("e_rst_start", tx_start, 0);
    check("e_rst_data", tx_data, 8'h00);
    check("e_rst_full", full, 0);
    check("e_rst_wr_ready", wr_ready, 1);
`ifdef UART_TXQ_LEVEL_EN
    check("e_rst_level", level, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    man_busy = 1'b0;
    repeat (20) step();
    check("e_discarded", lq_data.size(), base + 1);
    check("e_empty_after", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
